// File: rtl/sp_ram_pm_pkg.sv
// Shared types and helpers for the banked single-port RAM wrapper.
// No ports: provides the per-bank power state encoding, the bank-index width
// helper and the byte-to-word address offset.
package sp_ram_pm_pkg;

  typedef enum logic [1:0] {
    AWAKE  = 2'd0,
    SLEEP  = 2'd1,
    WAKING = 2'd2
  } bank_state_e;

  localparam int WORD_OFFSET = 2;

  // Bank index needs at least one bit even for a single bank.
  function automatic int bank_idx_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Behavioural single-port 32-bit RAM macro with byte-enabled writes and a
// registered read port.
// Ports: clk; en (access strobe); we (write); be[3:0] (byte enables);
//        addr (word address); wdata; rdata (valid the cycle after a read).
module sp_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sp_ram_bank_pm.sv
// Per-bank idle-sleep / wake controller.
// Ports: clk, rst_i (sync, active-high); access_i (bank enabled this cycle);
//        wake_req_i (a request targets this bank); bypass_en_i (hold awake);
//        awake_o (bank may be granted); sleep_o (registered retention control).
//
// state  | meaning
// AWAKE  | accessible, idle counter running
// SLEEP  | retention asserted, waiting for a wake source
// WAKING | retention released, wake counter running down
module sp_ram_bank_pm
  import sp_ram_pm_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic access_i,
  input  logic wake_req_i,
  input  logic bypass_en_i,
  output logic awake_o,
  output logic sleep_o
);

  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_TC = (IDLE_CYCLES > 0) ? IW'(IDLE_CYCLES - 1) : '0;
  localparam logic [WW-1:0] WAKE_LD = WW'(WAKE_CYCLES - 1);
  localparam bit SLEEP_EN = (IDLE_CYCLES != 0);

  bank_state_e   state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= AWAKE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      sleep_o  <= 1'b0;
    end else begin
      case (state)
        AWAKE: begin
          // An access on the threshold cycle keeps the bank awake.
          if (access_i || bypass_en_i) begin
            idle_cnt <= '0;
          end else if (SLEEP_EN && idle_cnt == IDLE_TC) begin
            state    <= SLEEP;
            sleep_o  <= 1'b1;
            idle_cnt <= '0;
          end else if (SLEEP_EN) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SLEEP: begin
          if (wake_req_i || bypass_en_i) begin
            state    <= WAKING;
            wake_cnt <= WAKE_LD;
            sleep_o  <= 1'b0;
          end
        end
        WAKING: begin
          // Runs to completion even if the request is withdrawn.
          if (wake_cnt == '0) begin
            state    <= AWAKE;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        default: begin
          state   <= AWAKE;
          sleep_o <= 1'b0;
        end
      endcase
    end
  end

  assign awake_o = (state == AWAKE);

endmodule

// File: rtl/sp_banked_ram_pm_wrap.sv
// Word-interleaved banked single-port RAM with req/gnt/rvalid handshake and
// per-bank idle sleep.
// Ports: clk, rst_i (sync, active-high); req_i/gnt_o handshake; addr_i (byte
//        address, [1:0] ignored); we_i, be_i, wdata_i; rvalid_o/rdata_o
//        response (rdata_o holds until the next read response);
//        bypass_en_i (keep all banks awake); bank_sleep_o (retention per bank).
// Build option: SP_RAM_OUT_REG_EN adds one output register stage so the
// response arrives two cycles after the grant.
module sp_banked_ram_pm_wrap
  import sp_ram_pm_pkg::*;
#(
  parameter int RAM_SIZE    = 32768,
  parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BANKS   = 4,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    bypass_en_i,
  output logic [NUM_BANKS-1:0]    bank_sleep_o
);

  localparam int BB         = bank_idx_width(NUM_BANKS);
  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int ROW_W      = ADDR_WIDTH - WORD_OFFSET - BANK_BITS;
  localparam int BANK_WORDS = RAM_SIZE / (4 * NUM_BANKS);

  logic [BB-1:0]         bank_sel;
  logic [ROW_W-1:0]      row;
  logic [NUM_BANKS-1:0]  bank_awake;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [1:0]            addr_unused;

  assign addr_unused = addr_i[1:0];

  if (NUM_BANKS > 1) begin : g_multi
    assign bank_sel = addr_i[WORD_OFFSET +: BB];
  end else begin : g_single
    assign bank_sel = '0;
  end

  assign row   = addr_i[ADDR_WIDTH-1 : WORD_OFFSET + BANK_BITS];
  assign gnt_o = req_i && bank_awake[bank_sel];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = gnt_o && (bank_sel == BB'(b));

    sp_ram_bank_pm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_pm (
      .clk         (clk),
      .rst_i       (rst_i),
      .access_i    (bank_en[b]),
      .wake_req_i  (req_i && (bank_sel == BB'(b))),
      .bypass_en_i (bypass_en_i),
      .awake_o     (bank_awake[b]),
      .sleep_o     (bank_sleep_o[b])
    );

    sp_ram #(
      .DEPTH (BANK_WORDS),
      .AW    (ROW_W)
    ) u_ram (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (we_i),
      .be    (be_i),
      .addr  (row),
      .wdata (wdata_i),
      .rdata (bank_rdata[b])
    );
  end

  logic                  rvalid_q;
  logic                  rd_q;
  logic [BB-1:0]         bank_q;
  logic [DATA_WIDTH-1:0] rdata_hold;
  logic [DATA_WIDTH-1:0] rdata_int;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      rd_q       <= 1'b0;
      bank_q     <= '0;
      rdata_hold <= '0;
    end else begin
      rvalid_q <= gnt_o;
      rd_q     <= gnt_o && !we_i;
      if (gnt_o) bank_q <= bank_sel;
      if (rd_q) rdata_hold <= bank_rdata[bank_q];
    end
  end

  // Macro outputs are only trusted in the cycle after a read; otherwise
  // present the last read value.
  assign rdata_int = rd_q ? bank_rdata[bank_q] : rdata_hold;

`ifdef SP_RAM_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rvalid_q;
      rdata_o  <= rdata_int;
    end
  end
`else
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_int;
`endif

endmodule

// File: tb/tb_sp_banked_ram_pm_wrap.sv
// Directed self-checking bench for sp_banked_ram_pm_wrap with IDLE_CYCLES=8,
// WAKE_CYCLES=4. Inputs change on the falling edge, outputs are sampled on the
// falling edge or 1 time unit after a rising edge.
module tb_sp_banked_ram_pm_wrap;

`ifdef SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i, bypass_en_i;
  logic [14:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic [3:0]  bank_sleep_o;

  int          total = 0;
  int          passed = 0;
  logic [31:0] last_rd;
  logic [3:0]  s1;
  int          bad;

  always #5 clk = ~clk;

  sp_banked_ram_pm_wrap #(
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .bypass_en_i  (bypass_en_i),
    .bank_sleep_o (bank_sleep_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on a falling edge and hold it until granted (bounded).
  // Returns after the granting rising edge; s1o is bank_sleep_o one edge in.
  task automatic access(input logic [14:0] a, input logic wr, input logic [3:0] b,
                        input logic [31:0] d, output int waits, output logic [3:0] s1o);
    @(negedge clk);
    req_i = 1'b1; addr_i = a; we_i = wr; be_i = b; wdata_i = d;
    waits = 0;
    #1;
    s1o = bank_sleep_o;
    while (!gnt_o && waits < 20) begin
      @(posedge clk); #1;
      if (waits == 0) s1o = bank_sleep_o;
      @(negedge clk); #1;
      waits++;
    end
    chk("grant_seen", {31'd0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [14:0] a, input logic wr,
                      input logic [3:0] b, input logic [31:0] d, input int exp_waits,
                      input logic [31:0] exp_rd, output logic [3:0] s1o);
    int waits;
    access(a, wr, b, d, waits, s1o);
    chk({tag, "_wait"}, 32'(waits), 32'(exp_waits));
    if (LAT == 2) begin
      @(posedge clk); #1;
    end
    chk({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
    if (!wr) last_rd = exp_rd;
    chk({tag, "_rdata"}, rdata_o, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0;
    addr_i = '0; be_i = '0; wdata_i = '0; last_rd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_sleep", {28'd0, bank_sleep_o}, 32'd0);
    @(negedge clk) rst_i = 1'b0;

    // Write then read after reset; write response leaves rdata_o at 0.
    xfer("wr_10", 15'h0010, 1'b1, 4'hF, 32'hDEADBEEF, 0, 32'h0, s1);
    xfer("rd_10", 15'h0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF, s1);

    // Byte enables and bank/row mapping with all banks held awake.
    @(negedge clk) bypass_en_i = 1'b1;
    xfer("wr_00", 15'h0000, 1'b1, 4'hF, 32'hA0A0A0A0, 0, 32'h0, s1);
    xfer("wr_08", 15'h0008, 1'b1, 4'hF, 32'hA2A2A2A2, 0, 32'h0, s1);
    xfer("wr_0c", 15'h000C, 1'b1, 4'hF, 32'hA3A3A3A3, 0, 32'h0, s1);
    xfer("wr_04", 15'h0004, 1'b1, 4'hF, 32'hFFFFFFFF, 0, 32'h0, s1);
    xfer("wr_04_be", 15'h0004, 1'b1, 4'h1, 32'h00000012, 0, 32'h0, s1);
    xfer("wr_14", 15'h0014, 1'b1, 4'hF, 32'h00000055, 0, 32'h0, s1);
    xfer("rd_04", 15'h0004, 1'b0, 4'hF, 32'h0, 0, 32'hFFFFFF12, s1);
    xfer("rd_00", 15'h0000, 1'b0, 4'hF, 32'h0, 0, 32'hA0A0A0A0, s1);
    xfer("rd_08", 15'h0008, 1'b0, 4'hF, 32'h0, 0, 32'hA2A2A2A2, s1);
    xfer("rd_0c", 15'h000C, 1'b0, 4'hF, 32'h0, 0, 32'hA3A3A3A3, s1);
    xfer("rd_10b", 15'h0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF, s1);
    xfer("rd_14", 15'h0014, 1'b0, 4'hF, 32'h0, 0, 32'h00000055, s1);

    // Idle sleep after exactly 8 unaccessed cycles.
    @(negedge clk) bypass_en_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("idle7_awake", {28'd0, bank_sleep_o}, 32'h0);
    @(posedge clk);
    #1 chk("idle8_sleep", {28'd0, bank_sleep_o}, 32'hF);

    // Wake bank 2 by a read: grant after WAKE_CYCLES+1 edges, only bank 2 wakes.
    xfer("wake_b2", 15'h0008, 1'b0, 4'hF, 32'h0, 5, 32'hA2A2A2A2, s1);
    chk("wake_b2_sleep_fall", {28'd0, s1}, 32'hB);
    chk("wake_b2_only", {28'd0, bank_sleep_o}, 32'hB);
    repeat (12) @(posedge clk);
    #1 chk("all_asleep", {28'd0, bank_sleep_o}, 32'hF);

    // Bypass wakes every bank and keeps them awake.
    @(negedge clk) bypass_en_i = 1'b1;
    @(posedge clk);
    #1 chk("bypass_sleep_fall", {28'd0, bank_sleep_o}, 32'h0);
    repeat (4) @(posedge clk);
    xfer("byp_rd_00", 15'h0000, 1'b0, 4'hF, 32'h0, 0, 32'hA0A0A0A0, s1);
    xfer("byp_rd_04", 15'h0004, 1'b0, 4'hF, 32'h0, 0, 32'hFFFFFF12, s1);
    xfer("byp_rd_08", 15'h0008, 1'b0, 4'hF, 32'h0, 0, 32'hA2A2A2A2, s1);
    xfer("byp_rd_0c", 15'h000C, 1'b0, 4'hF, 32'h0, 0, 32'hA3A3A3A3, s1);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bank_sleep_o != 4'h0) bad++;
    end
    chk("bypass_hold", 32'(bad), 32'd0);
    xfer("byp_rd_10", 15'h0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF, s1);

    // Threshold race: access bank 0 on the 8th idle cycle.
    @(negedge clk) bypass_en_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("race_pre", {28'd0, bank_sleep_o}, 32'h0);
    @(negedge clk);
    req_i = 1'b1; addr_i = 15'h0000; we_i = 1'b0; be_i = 4'hF;
    #1 chk("race_gnt", {31'd0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("race_sleep", {28'd0, bank_sleep_o}, 32'hE);
    chk("race_rvalid0", {31'd0, rvalid_o}, (LAT == 1) ? 32'd1 : 32'd0);
    last_rd = 32'hA0A0A0A0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("race_rvalid1", {31'd0, rvalid_o}, (LAT == 2) ? 32'd1 : 32'd0);
        chk("race_rdata", rdata_o, 32'hA0A0A0A0);
      end
      chk($sformatf("race_idle%0d", k), {28'd0, bank_sleep_o}, (k < 8) ? 32'hE : 32'hF);
    end

    // Reset during WAKING forces AWAKE and no response.
    @(negedge clk);
    req_i = 1'b1; addr_i = 15'h0004; we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1; req_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_wake_sleep", {28'd0, bank_sleep_o}, 32'h0);
    chk("rst_wake_rvalid", {31'd0, rvalid_o}, 32'd0);
    @(negedge clk) rst_i = 1'b0;
    last_rd = 32'h0;
    xfer("post_rst_rd_04", 15'h0004, 1'b0, 4'hF, 32'h0, 0, 32'hFFFFFF12, s1);

    // Reset on the grant edge cancels the pending response.
    @(negedge clk);
    req_i = 1'b1; addr_i = 15'h0000; we_i = 1'b0; rst_i = 1'b1;
    #1 chk("cancel_gnt", {31'd0, gnt_o}, 32'd1);
    @(posedge clk);
    #1 chk("cancel_rvalid0", {31'd0, rvalid_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0; req_i = 1'b0;
    @(posedge clk); #1;
    chk("cancel_rvalid1", {31'd0, rvalid_o}, 32'd0);
    chk("cancel_rdata", rdata_o, 32'd0);
    last_rd = 32'h0;

    // Back-to-back stream of 16 reads across all banks.
    @(negedge clk) bypass_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xfer($sformatf("str_wr%0d", i), 15'h0100 + 15'(4 * i), 1'b1, 4'hF,
           32'h1000 + 32'(i), 0, 32'h0, s1);
    end
    for (int c = 0; c < 16 + LAT; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        chk($sformatf("str_rvalid%0d", c - LAT), {31'd0, rvalid_o}, 32'd1);
        chk($sformatf("str_rdata%0d", c - LAT), rdata_o, 32'h1000 + 32'(c - LAT));
      end
      if (c < 16) begin
        req_i = 1'b1; addr_i = 15'h0100 + 15'(4 * c); we_i = 1'b0;
        #1 chk($sformatf("str_gnt%0d", c), {31'd0, gnt_o}, 32'd1);
      end else begin
        req_i = 1'b0;
      end
    end
    @(negedge clk);
    chk("str_end_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("str_end_rdata", rdata_o, 32'h0000100F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
